multicycle_control_fsm: RTL
===========================

# multicycle_control_fsm

Control sequencer for the multicycle RISC-V core. It steps each instruction through fetch, decode, execute, memory and writeback states, and drives the per-cycle datapath selects, the ALUOp code for the ALU decoder, and the register, memory and PC write strobes. It waits on a memory ready handshake and traps unsupported opcodes. It sits between the instruction register and the shared ALU/memory datapath; the ALU decoder consumes its `alu_op_o`.

## Interface
- No parameters.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `op_i`  in  7  opcode from the instruction register
- `func3_i`  in  3  func3 from the instruction register
- `zero_i`  in  1  ALU zero flag
- `mem_ready_i`  in  1  memory completes the access this cycle
- `pc_write_o`  out  1  PC register enable
- `adr_src_o`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `mem_write_o`  out  1  memory write strobe
- `ir_write_o`  out  1  instruction register and OldPC enable
- `reg_write_o`  out  1  register file write
- `result_src_o`  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- `alu_src_a_o`  out  2  00 = PC, 01 = OldPC, 10 = rs1
- `alu_src_b_o`  out  2  00 = rs2, 01 = imm, 10 = constant 4
- `alu_op_o`  out  2  00 = add, 01 = sub, 10 = decode from func fields
- `imm_src_o`  out  2  00 = I, 01 = S, 10 = B, 11 = J
- `retire_o`  out  1  one-cycle pulse on the final cycle of an instruction
- `illegal_o`  out  1  sticky trap flag

## Operation
- Moore FSM. `pc_write_o` = `pc_update | (branch & taken)`, where taken = `zero_i ^ func3_i[0]` (covers beq and bne).
- Any select or strobe not listed for a state is 0.
- States, their outputs, and their transitions:
  - FETCH: adr 0, a 00, b 10, alu_op 00, result 10. `ir_write` and `pc_update` equal `mem_ready_i`. Goes to DECODE when ready, otherwise stays in FETCH.
  - DECODE: a 01, b 01, alu_op 00 (precomputes the branch target). Next state depends on `op_i`:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1100011 → BRANCH
    - 1101111 → JAL
    - anything else → ILLEGAL
  - MEMADR: a 10, b 01, alu_op 00. Goes to MEMREAD if `op_i[5]`=0, otherwise MEMWRITE.
  - MEMREAD: adr 1, result 00. Goes to MEMWB when ready, otherwise holds.
  - MEMWRITE: adr 1, result 00, `mem_write` = 1 for every cycle until ready. Goes to FETCH when ready; `retire` is asserted on the ready cycle.
  - MEMWB: result 01, reg_write. Goes to FETCH; asserts retire.
  - EXECR: a 10, b 00, alu_op 10. Goes to ALUWB.
  - EXECI: a 10, b 01, alu_op 10. Goes to ALUWB.
  - ALUWB: result 00, reg_write. Goes to FETCH; asserts retire.
  - BRANCH: a 10, b 00, alu_op 01, result 00, branch = 1. Goes to FETCH; asserts retire.
  - JAL: a 01, b 10, alu_op 00, result 00, pc_update. Goes to ALUWB.
  - ILLEGAL: all strobes 0, `illegal_o` = 1. Absorbing; only reset exits.
- `imm_src_o` is combinational from `op_i`:
  - 0100011 → 01
  - 1100011 → 10
  - 1101111 → 11
  - otherwise → 00

## Timing
- Reset: while `rst_n` is low, state = FETCH immediately. Output values during reset:
  - `adr_src_o` 0
  - `alu_src_a_o` 00
  - `alu_src_b_o` 10
  - `alu_op_o` 00
  - `result_src_o` 10
  - `mem_write_o`, `reg_write_o`, `retire_o` 0
  - `illegal_o` 0
  - `ir_write_o` and `pc_write_o` gated to 0 while reset is asserted
- A reset asserted mid-instruction abandons the instruction; no write strobe fires after the asynchronous assertion.
- Latency in cycles with `mem_ready_i` held at 1:
  - beq/bne: 3
  - R, I, sw, jal: 4
  - lw: 5
- Each cycle of `mem_ready_i` = 0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle; the outputs stay constant while waiting.
- Exactly one `retire_o` pulse per legal instruction; none for an illegal one.
- `op_i` and `func3_i` must stay stable from DECODE to the final state; `zero_i` is sampled in BRANCH only.

## Test plan
- Reset then R-type: release `rst_n`, `mem_ready_i`=1, `op_i`=0110011. Required: states FETCH, DECODE, EXECR, ALUWB; `alu_op_o`=10 in EXECR; `reg_write_o` and `retire_o` high in cycle 4 only.
- lw with stall: `op_i`=0000011, `mem_ready_i` low for 2 cycles in MEMREAD. Required: MEMREAD lasts 3 cycles with `adr_src_o`=1; MEMWB `result_src_o`=01; 7 cycles total.
- Branch: `op_i`=1100011 in BRANCH.
  - `func3_i`=000, `zero_i`=1 → `pc_write_o`=1.
  - `func3_i`=000, `zero_i`=0 → `pc_write_o`=0.
  - `func3_i`=001, `zero_i`=0 → `pc_write_o`=1.
  - In all three cases `alu_op_o`=01 and `retire_o`=1.
- sw: `op_i`=0100011, `mem_ready_i` low for 1 cycle. Required: `mem_write_o` high for exactly 2 cycles; `imm_src_o`=01; then FETCH.
- Illegal: `op_i`=1111111. Required: `illegal_o` goes high in the cycle after DECODE and stays high; all strobes stay 0 for 10 cycles; no retire; cleared by `rst_n`.
- Mid-op reset: assert `rst_n` low asynchronously during MEMWRITE. Required: `mem_write_o` drops within the same cycle, and the outputs match their reset values.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_fsm
// Purpose  : Moore control sequencer for the multicycle RISC-V core. It steps
//            each instruction through fetch/decode/execute/memory/writeback
//            and drives the datapath selects and write strobes.
// Revision : 1.0
// ============================================================================
module multicycle_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op_i,
  input  logic [2:0] func3_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       pc_write_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output logic [1:0] imm_src_o,
  output logic       retire_o,
  output logic       illegal_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWRITE = 4'd4;
  localparam logic [3:0] S_MEMWB    = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  logic [3:0] r_state;
  logic [3:0] w_next;

  logic       w_pc_update;
  logic       w_branch;
  logic       w_taken;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_retire;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic       w_unused_func3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_RTYPE:          w_next = S_EXECR;
          OP_ITYPE:          w_next = S_EXECI;
          OP_BRANCH:         w_next = S_BRANCH;
          OP_JAL:            w_next = S_JAL;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   w_next = op_i[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  w_next = mem_ready_i ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next = mem_ready_i ? S_FETCH : S_MEMWRITE;
      S_MEMWB:    w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_ILLEGAL:  w_next = S_ILLEGAL;
      default:    w_next = S_FETCH;
    endcase
  end

  // Outputs depend on state only, except the handshake-qualified strobes in
  // FETCH and MEMWRITE which follow mem_ready_i.
  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_retire     = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = mem_ready_i;
        w_pc_update  = mem_ready_i;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_adr_src = 1'b1;
      end
      S_MEMWRITE: begin
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
        w_retire    = mem_ready_i;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
      end
      S_BRANCH: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
        w_retire    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // bne is beq with func3[0] set, so the zero flag polarity flips.
  assign w_taken = zero_i ^ func3_i[0];
  assign w_unused_func3 = ^func3_i[2:1];

  // Strobes are gated by rst_n so nothing writes while reset is held.
  assign pc_write_o   = rst_n & (w_pc_update | (w_branch & w_taken));
  assign ir_write_o   = rst_n & w_ir_write;
  assign mem_write_o  = rst_n & w_mem_write;
  assign reg_write_o  = rst_n & w_reg_write;
  assign retire_o     = rst_n & w_retire;
  assign adr_src_o    = w_adr_src;
  assign result_src_o = w_result_src;
  assign alu_src_a_o  = w_alu_src_a;
  assign alu_src_b_o  = w_alu_src_b;
  assign alu_op_o     = w_alu_op;
  assign illegal_o    = (r_state == S_ILLEGAL);

  always_comb begin
    case (op_i)
      OP_STORE:  imm_src_o = 2'b01;
      OP_BRANCH: imm_src_o = 2'b10;
      OP_JAL:    imm_src_o = 2'b11;
      default:   imm_src_o = 2'b00;
    endcase
  end

endmodule
`default_nettype wire
